// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path:
// FSM states, opcodes, ALUOp and datapath select codes.
package riscv_ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  typedef enum logic [3:0] {
    FETCH    = S_FETCH,
    DECODE   = S_DECODE,
    MEMADR   = S_MEMADR,
    MEMREAD  = S_MEMREAD,
    MEMWB    = S_MEMWB,
    MEMWRITE = S_MEMWRITE,
    EXECR    = S_EXECR,
    EXECI    = S_EXECI,
    ALUWB    = S_ALUWB,
    BEQ      = S_BEQ,
    JAL      = S_JAL,
    TRAP     = S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  typedef struct packed {
    logic       mem_req;
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // States whose exit to FETCH retires an instruction.
  function automatic logic is_retire_state(state_t s);
    return (s == MEMWB) || (s == MEMWRITE) ||
           (s == ALUWB) || (s == BEQ);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode: state plus mem_ready and zero
// to every datapath enable and select.
module mc_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  logic pc_update;
  logic branch;
  ctrl_t c;

  always_comb begin
    c         = '0;
    pc_update = 1'b0;
    branch    = 1'b0;
    unique case (state)
      FETCH: begin
        c.mem_req    = 1'b1;
        c.adr_src    = ADR_PC;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALU;
        c.alu_op     = ALUOP_ADD;
        c.ir_write   = mem_ready;
        pc_update    = mem_ready;
      end
      DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
      end
      MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = ADR_ALUOUT;
      end
      MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.adr_src   = ADR_ALUOUT;
        c.mem_write = mem_ready;
      end
      EXECR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_FUNCT;
      end
      EXECI: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      BEQ: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_SUB;
        branch      = 1'b1;
      end
      JAL: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_FOUR;
        pc_update   = 1'b1;
      end
      default: c = '0;
    endcase
    c.pc_write = pc_update | (branch & zero);
  end

  assign ctrl = c;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle core main controller: state register, next state, instret.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes and expose illegal.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [CNT_W-1:0] instret
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             retire;
  ctrl_t            ctrl;
  ctrl_t            gated;

  always_comb begin
    nxt = state;
    unique case (state)
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):  nxt = MEMADR;
          (op == OP_R):   nxt = EXECR;
          (op == OP_I):   nxt = EXECI;
          (op == OP_BEQ): nxt = BEQ;
          (op == OP_JAL): nxt = JAL;
`ifdef ILLEGAL_TRAP_EN
          default:        nxt = TRAP;
`else
          default:        nxt = FETCH;
`endif
        endcase
      end
      MEMADR:   nxt = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    nxt = FETCH;
      MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
      EXECR:    nxt = ALUWB;
      EXECI:    nxt = ALUWB;
      ALUWB:    nxt = FETCH;
      BEQ:      nxt = FETCH;
      JAL:      nxt = ALUWB;
      TRAP:     nxt = TRAP;
      default:  nxt = FETCH;
    endcase
  end

  assign retire = (nxt == FETCH) && is_retire_state(state);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (retire) cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic ill_q;

  always_ff @(posedge clk) begin
    if (!rst_n)           ill_q <= 1'b0;
    else if (nxt == TRAP) ill_q <= 1'b1;
  end

  assign illegal = rst_n & ill_q;
`endif

  mc_ctrl_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  // Reset is synchronous, so the outputs are masked directly by rst_n.
  assign gated      = rst_n ? ctrl : '0;
  assign mem_req    = gated.mem_req;
  assign pc_write   = gated.pc_write;
  assign adr_src    = gated.adr_src;
  assign ir_write   = gated.ir_write;
  assign mem_write  = gated.mem_write;
  assign reg_write  = gated.reg_write;
  assign result_src = gated.result_src;
  assign alu_src_a  = gated.alu_src_a;
  assign alu_src_b  = gated.alu_src_b;
  assign alu_op     = gated.alu_op;
  assign instret    = rst_n ? cnt : '0;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed-vector bench for multicycle_ctrl_fsm; each cycle compares
// the packed control word, instret and (if built) illegal.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] L_LW  = 7'b0000011;
  localparam logic [6:0] L_SW  = 7'b0100011;
  localparam logic [6:0] L_R   = 7'b0110011;
  localparam logic [6:0] L_I   = 7'b0010011;
  localparam logic [6:0] L_BEQ = 7'b1100011;
  localparam logic [6:0] L_JAL = 7'b1101111;
  localparam logic [6:0] L_BAD = 7'b1111111;

  // {mem_req,pc_write,adr_src,ir_write,mem_write,reg_write,
  //  result_src,alu_src_a,alu_src_b,alu_op}
  localparam logic [13:0] C_ZERO  = 14'b000000_00_00_00_00;
  localparam logic [13:0] C_FET_R = 14'b110100_10_00_10_00;
  localparam logic [13:0] C_FET_W = 14'b100000_10_00_10_00;
  localparam logic [13:0] C_DEC   = 14'b000000_00_01_01_00;
  localparam logic [13:0] C_MADR  = 14'b000000_00_10_01_00;
  localparam logic [13:0] C_MRD   = 14'b101000_00_00_00_00;
  localparam logic [13:0] C_MWB   = 14'b000001_01_00_00_00;
  localparam logic [13:0] C_MWR_R = 14'b101010_00_00_00_00;
  localparam logic [13:0] C_MWR_W = 14'b101000_00_00_00_00;
  localparam logic [13:0] C_EXR   = 14'b000000_00_10_00_10;
  localparam logic [13:0] C_EXI   = 14'b000000_00_10_01_10;
  localparam logic [13:0] C_AWB   = 14'b000001_00_00_00_00;
  localparam logic [13:0] C_BEQ_T = 14'b010000_00_10_00_01;
  localparam logic [13:0] C_BEQ_N = 14'b000000_00_10_00_01;
  localparam logic [13:0] C_JAL   = 14'b010000_00_01_10_00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        pc_write;
  logic        adr_src;
  logic        ir_write;
  logic        mem_write;
  logic        reg_write;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [31:0] instret;
  logic [13:0] ctl;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] exp_cnt;
  logic        exp_ill;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .instret    (instret)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal    (illegal)
`endif
  );

  assign ctl = {mem_req, pc_write, adr_src, ir_write, mem_write,
                reg_write, result_src, alu_src_a, alu_src_b, alu_op};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge.
  task automatic cyc(input string tag, input logic r, input logic mr,
                     input logic z, input logic [13:0] e);
    rst_n     = r;
    mem_ready = mr;
    zero      = z;
    @(negedge clk);
    chk(tag, 32'(ctl), 32'(e));
    chk({tag, "_cnt"}, instret, exp_cnt);
`ifdef ILLEGAL_TRAP_EN
    chk({tag, "_ill"}, 32'(illegal), 32'(exp_ill));
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b0;
    op        = L_R;
    exp_cnt   = '0;
    exp_ill   = 1'b0;
    @(posedge clk);
    #1;

    repeat (3) cyc("rst", 1'b0, 1'b1, 1'b1, C_ZERO);

    // R-type
    cyc("r_fet", 1'b1, 1'b1, 1'b0, C_FET_R);
    cyc("r_dec", 1'b1, 1'b1, 1'b0, C_DEC);
    cyc("r_exe", 1'b1, 1'b1, 1'b1, C_EXR);
    cyc("r_wb",  1'b1, 1'b1, 1'b0, C_AWB);
    exp_cnt++;

    // I-ALU
    op = L_I;
    cyc("i_fet", 1'b1, 1'b1, 1'b0, C_FET_R);
    cyc("i_dec", 1'b1, 1'b1, 1'b0, C_DEC);
    cyc("i_exe", 1'b1, 1'b1, 1'b0, C_EXI);
    cyc("i_wb",  1'b1, 1'b1, 1'b0, C_AWB);
    exp_cnt++;

    // LW with two wait cycles; MEMWB is the 7th cycle
    op = L_LW;
    cyc("lw_fet", 1'b1, 1'b1, 1'b0, C_FET_R);
    cyc("lw_dec", 1'b1, 1'b1, 1'b0, C_DEC);
    cyc("lw_adr", 1'b1, 1'b1, 1'b0, C_MADR);
    cyc("lw_rw0", 1'b1, 1'b0, 1'b0, C_MRD);
    cyc("lw_rw1", 1'b1, 1'b0, 1'b0, C_MRD);
    cyc("lw_rd",  1'b1, 1'b1, 1'b0, C_MRD);
    cyc("lw_wb",  1'b1, 1'b1, 1'b0, C_MWB);
    exp_cnt++;

    // SW with a fetch wait and a write wait
    op = L_SW;
    cyc("sw_fw",  1'b1, 1'b0, 1'b0, C_FET_W);
    cyc("sw_fet", 1'b1, 1'b1, 1'b0, C_FET_R);
    cyc("sw_dec", 1'b1, 1'b1, 1'b0, C_DEC);
    cyc("sw_adr", 1'b1, 1'b1, 1'b0, C_MADR);
    cyc("sw_ww",  1'b1, 1'b0, 1'b0, C_MWR_W);
    cyc("sw_wr",  1'b1, 1'b1, 1'b0, C_MWR_R);
    exp_cnt++;

    // BEQ taken, then not taken
    op = L_BEQ;
    cyc("bt_fet", 1'b1, 1'b1, 1'b0, C_FET_R);
    cyc("bt_dec", 1'b1, 1'b1, 1'b0, C_DEC);
    cyc("bt_beq", 1'b1, 1'b1, 1'b1, C_BEQ_T);
    exp_cnt++;
    cyc("bn_fet", 1'b1, 1'b1, 1'b0, C_FET_R);
    cyc("bn_dec", 1'b1, 1'b1, 1'b1, C_DEC);
    cyc("bn_beq", 1'b1, 1'b1, 1'b0, C_BEQ_N);
    exp_cnt++;

    // JAL
    op = L_JAL;
    cyc("j_fet", 1'b1, 1'b1, 1'b0, C_FET_R);
    cyc("j_dec", 1'b1, 1'b1, 1'b0, C_DEC);
    cyc("j_jal", 1'b1, 1'b1, 1'b0, C_JAL);
    cyc("j_wb",  1'b1, 1'b1, 1'b0, C_AWB);
    exp_cnt++;

    // Illegal opcode
    op = L_BAD;
    cyc("x_fet", 1'b1, 1'b1, 1'b0, C_FET_R);
    cyc("x_dec", 1'b1, 1'b1, 1'b0, C_DEC);
`ifdef ILLEGAL_TRAP_EN
    exp_ill = 1'b1;
    repeat (3) cyc("x_trap", 1'b1, 1'b1, 1'b1, C_ZERO);
    exp_ill = 1'b0;
    exp_cnt = '0;
    repeat (2) cyc("x_rst", 1'b0, 1'b1, 1'b0, C_ZERO);
`endif

    // R-type after illegal: back in FETCH, count unchanged
    op = L_R;
    cyc("r2_fet", 1'b1, 1'b1, 1'b0, C_FET_R);
    cyc("r2_dec", 1'b1, 1'b1, 1'b0, C_DEC);
    cyc("r2_exe", 1'b1, 1'b1, 1'b0, C_EXR);
    cyc("r2_wb",  1'b1, 1'b1, 1'b0, C_AWB);
    exp_cnt++;

    // Reset in the middle of a stalled SW
    op = L_SW;
    cyc("ms_fet", 1'b1, 1'b1, 1'b0, C_FET_R);
    cyc("ms_dec", 1'b1, 1'b1, 1'b0, C_DEC);
    cyc("ms_adr", 1'b1, 1'b1, 1'b0, C_MADR);
    cyc("ms_ww",  1'b1, 1'b0, 1'b0, C_MWR_W);
    exp_cnt = '0;
    cyc("ms_rst0", 1'b0, 1'b0, 1'b0, C_ZERO);
    cyc("ms_rst1", 1'b0, 1'b1, 1'b0, C_ZERO);

    // Recovery
    op = L_BEQ;
    cyc("rc_fet", 1'b1, 1'b1, 1'b0, C_FET_R);
    cyc("rc_dec", 1'b1, 1'b1, 1'b0, C_DEC);
    cyc("rc_beq", 1'b1, 1'b1, 1'b1, C_BEQ_T);
    exp_cnt++;
    cyc("rc_fw",  1'b1, 1'b0, 1'b0, C_FET_W);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
